// File: rtl/list_pkg.sv
// ============================================================================
// list_pkg : state encoding and record field layout for list_unlink
// Rev 1.0
// ============================================================================
`default_nettype none

package list_pkg;

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_RD_ITEM = 3'd1;
    localparam logic [2:0] c_S_RD_PRI  = 3'd2;
    localparam logic [2:0] c_S_WR_PREV = 3'd3;
    localparam logic [2:0] c_S_WR_NEXT = 3'd4;
    localparam logic [2:0] c_S_WR_PRI  = 3'd5;
    localparam logic [2:0] c_S_DONE    = 3'd6;

    // Item record {payload, prio, prev, next}; priority record {head, tail, count}.
    function automatic int item_width(input int id_w, input int prio_w, input int payload_w);
        return payload_w + prio_w + 2 * id_w;
    endfunction

    function automatic int item_next_lsb();
        return 0;
    endfunction

    function automatic int item_prev_lsb(input int id_w);
        return id_w;
    endfunction

    function automatic int item_prio_lsb(input int id_w);
        return 2 * id_w;
    endfunction

    function automatic int item_payload_lsb(input int id_w, input int prio_w);
        return 2 * id_w + prio_w;
    endfunction

    function automatic int pri_count_lsb();
        return 0;
    endfunction

    function automatic int pri_tail_lsb(input int id_w);
        return id_w;
    endfunction

    function automatic int pri_head_lsb(input int id_w);
        return 2 * id_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/list_unlink.sv
// ============================================================================
// list_unlink : removes one item from a circular doubly linked priority list
// Rev 1.0
// ============================================================================
`default_nettype none

module list_unlink
    import list_pkg::*;
#(
    parameter int ID_W      = 8,
    parameter int PRIO_W    = 6,
    parameter int PAYLOAD_W = 32
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic                              start,
    input  logic                              mode,
    input  logic [ID_W-1:0]                   id_in,
    input  logic [PRIO_W-1:0]                 prio_in,
    output logic                              busy,
    output logic                              done,
    output logic                              err,
    output logic [ID_W-1:0]                   id_out,
    output logic [PRIO_W-1:0]                 prio_out,
    output logic [PAYLOAD_W-1:0]              payload_out,
    output logic                              pri_empty,
    output logic [ID_W-1:0]                   item_addr,
    input  logic [PAYLOAD_W+PRIO_W+2*ID_W-1:0] item_rdata,
    output logic [PAYLOAD_W+PRIO_W+2*ID_W-1:0] item_wdata,
    output logic                              item_we_prev,
    output logic                              item_we_next,
    output logic [PRIO_W-1:0]                 pri_addr,
    input  logic [3*ID_W-1:0]                 pri_rdata,
    output logic [3*ID_W-1:0]                 pri_wdata,
    output logic                              pri_we
);

    localparam int c_NEXT_LSB  = item_next_lsb();
    localparam int c_PREV_LSB  = item_prev_lsb(ID_W);
    localparam int c_PRIO_LSB  = item_prio_lsb(ID_W);
    localparam int c_PAY_LSB   = item_payload_lsb(ID_W, PRIO_W);
    localparam int c_CNT_LSB   = pri_count_lsb();
    localparam int c_TAIL_LSB  = pri_tail_lsb(ID_W);
    localparam int c_HEAD_LSB  = pri_head_lsb(ID_W);
    localparam logic [ID_W-1:0] c_ZERO = '0;
    localparam logic [ID_W-1:0] c_ONE  = ID_W'(1);

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic                 r_mode;
    logic                 r_err;
    logic [ID_W-1:0]      r_id;
    logic [PRIO_W-1:0]    r_prio;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [ID_W-1:0]      r_prev;
    logic [ID_W-1:0]      r_next;
    logic [ID_W-1:0]      r_head;
    logic [ID_W-1:0]      r_tail;
    logic [ID_W-1:0]      r_count;

    logic [ID_W-1:0]      w_rd_head;
    logic [ID_W-1:0]      w_rd_tail;
    logic [ID_W-1:0]      w_rd_count;
    logic [ID_W-1:0]      w_head_new;
    logic [ID_W-1:0]      w_tail_new;
    logic                 w_run;

    assign w_rd_head  = pri_rdata[c_HEAD_LSB +: ID_W];
    assign w_rd_tail  = pri_rdata[c_TAIL_LSB +: ID_W];
    assign w_rd_count = pri_rdata[c_CNT_LSB  +: ID_W];

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= c_S_IDLE;
            r_mode    <= 1'b0;
            r_err     <= 1'b0;
            r_id      <= '0;
            r_prio    <= '0;
            r_payload <= '0;
            r_prev    <= '0;
            r_next    <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_mode <= mode;
                        r_id   <= id_in;
                        r_prio <= prio_in;
                        r_err  <= 1'b0;
                    end
                end
                c_S_RD_ITEM: begin
                    if (!r_err) begin
                        r_payload <= item_rdata[c_PAY_LSB  +: PAYLOAD_W];
                        r_prev    <= item_rdata[c_PREV_LSB +: ID_W];
                        r_next    <= item_rdata[c_NEXT_LSB +: ID_W];
                        if (!r_mode) begin
                            r_prio <= item_rdata[c_PRIO_LSB +: PRIO_W];
                        end
                    end
                end
                c_S_RD_PRI: begin
                    r_head  <= w_rd_head;
                    r_tail  <= w_rd_tail;
                    r_count <= w_rd_count;
                    if (w_rd_count == c_ZERO) begin
                        r_err <= 1'b1;
                    end else if (r_mode) begin
                        r_id <= w_rd_head;
                    end
                end
                default: ;
            endcase
        end
    end

    // An empty pop still passes through RD_ITEM (writes suppressed) so both
    // modes report err with the same latency.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_state_nxt = mode ? c_S_RD_PRI : c_S_RD_ITEM;
                end
            end
            c_S_RD_ITEM: begin
                if (r_err) begin
                    w_state_nxt = c_S_DONE;
                end else if (!r_mode) begin
                    w_state_nxt = c_S_RD_PRI;
                end else begin
                    w_state_nxt = (r_count > c_ONE) ? c_S_WR_PREV : c_S_WR_PRI;
                end
            end
            c_S_RD_PRI: begin
                if (w_rd_count == c_ZERO) begin
                    w_state_nxt = r_mode ? c_S_RD_ITEM : c_S_DONE;
                end else if (r_mode) begin
                    w_state_nxt = c_S_RD_ITEM;
                end else begin
                    w_state_nxt = (w_rd_count > c_ONE) ? c_S_WR_PREV : c_S_WR_PRI;
                end
            end
            c_S_WR_PREV: w_state_nxt = c_S_WR_NEXT;
            c_S_WR_NEXT: w_state_nxt = c_S_WR_PRI;
            c_S_WR_PRI:  w_state_nxt = c_S_DONE;
            c_S_DONE:    w_state_nxt = c_S_IDLE;
            default:     w_state_nxt = c_S_IDLE;
        endcase
    end

    // Status and enables are masked during reset so an abandoned op never writes.
    assign w_run = ~areset;

    assign busy         = w_run & (r_state != c_S_IDLE);
    assign done         = w_run & (r_state == c_S_DONE);
    assign err          = done & r_err;
    assign pri_empty    = done & ~r_err & (r_count == c_ONE);
    assign item_we_next = w_run & (r_state == c_S_WR_PREV);
    assign item_we_prev = w_run & (r_state == c_S_WR_NEXT);
    assign pri_we       = w_run & (r_state == c_S_WR_PRI);

    assign id_out      = r_id;
    assign prio_out    = r_prio;
    assign payload_out = r_payload;
    assign pri_addr    = r_prio;

    always_comb begin
        item_addr = r_id;
        case (r_state)
            c_S_WR_PREV: item_addr = r_prev;
            c_S_WR_NEXT: item_addr = r_next;
            default:     item_addr = r_id;
        endcase
    end

    // Both link fields always carry their own values, so prev == next needs no special case.
    assign item_wdata = {r_payload, r_prio, r_prev, r_next};

    assign w_head_new = (r_head == r_id) ? r_next : r_head;
    assign w_tail_new = (r_tail == r_id) ? r_prev : r_tail;
    assign pri_wdata  = (r_count == c_ONE) ? '0 : {w_head_new, w_tail_new, r_count - c_ONE};

endmodule

`default_nettype wire
